ps2_kbd_rx: RTL and testbench

PS/2 keyboard receiver that feeds the bus `keyboard_in` byte. It samples the external `ps2_clk`/`ps2_data` lines and deframes 11-bit device-to-host frames. Valid scancodes are buffered in a small show-ahead FIFO. The bus decoder reads the head byte at 0xffff_01xx and pops it with a one-cycle `rd_en` strobe.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_rx_fifo.sv | 57 +++++
 rtl/ps2_kbd_rx.sv | 156 +++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// frame geometry, default timeout and the bus device identifier.
package ps2_pkg;

  // Device-to-host frame deframing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Payload bits per frame (start, 8 data, parity, stop on the wire).
  localparam int PS2_DATA_BITS = 8;

  // Default mid-frame silence limit: 1 ms at a 50 MHz system clock.
  localparam int PS2_TIMEOUT_CYC = 50000;

  // Bus decode nibble selecting the keyboard at 0xffff_01xx.
  localparam logic [3:0] PS2_DEV_ID = 4'h1;

  // Odd parity over payload plus parity bit.
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] payload,
                                         input logic                     par);
    return ^{payload, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Generic synchronous show-ahead FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB. The head entry is presented
// combinationally and forced to zero while empty.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop frees the head slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; both pointers wrap modulo 2*DEPTH.
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; empty gating on dout keeps stale entries
  // invisible, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver feeding the bus keyboard_in byte. Synchronizes the
// raw PS/2 pins, deframes 11-bit device-to-host frames on falling ps2_clk,
// aborts stalled frames, and buffers good scancodes in a show-ahead FIFO
// popped by a one-cycle rd_en from the bus decoder.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int  FIFO_DEPTH  = 8,
  parameter int  TIMEOUT_CYC = PS2_TIMEOUT_CYC,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [PS2_DATA_BITS-1:0] kbd_data,
  output logic                     kbd_valid,
  output logic [CW-1:0]            kbd_count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int            TW      = $clog2(TIMEOUT_CYC);
  localparam int            BW      = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);

  // Synchronizer chains; reset to 1 because idle PS/2 lines are high.
  logic clk_meta, clk_sync, clk_hist;
  logic data_meta, data_sync;

  ps2_state_e               state;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic [BW-1:0]            bitcnt;
  logic                     par_bit;
  logic [TW-1:0]            tocnt;

  logic fall;
  logic stop_fall;
  logic frame_good;
  logic frame_bad;
  logic timeout;
  logic fifo_push;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic drop_ovf;

  // Two-flop synchronizers on both pins plus one history flop on the clock
  // for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_hist  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_hist  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_hist & ~clk_sync;

  // Frame outcome decode in the stop-bit fall cycle. The push goes straight
  // into the FIFO so the byte shows on kbd_data the following cycle.
  assign stop_fall  = (state == STOP) & fall;
  assign frame_good = stop_fall & data_sync & ps2_parity_ok(shreg, par_bit);
  assign frame_bad  = stop_fall & ~(data_sync & ps2_parity_ok(shreg, par_bit));
  assign fifo_pop   = rd_en & ~fifo_empty;
  assign fifo_push  = frame_good & (~fifo_full | fifo_pop);
  assign drop_ovf   = frame_good & fifo_full & ~fifo_pop;
  assign timeout    = (state != IDLE) & ~fall & (tocnt == TO_LAST);

  // Deframing FSM, timeout counter and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      par_bit   <= 1'b0;
      tocnt     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A fall with data high is a glitch, not a start bit.
          if (fall && !data_sync) begin
            state  <= DATA;
            bitcnt <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            shreg  <= {data_sync, shreg[PS2_DATA_BITS-1:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == BIT_LAST) state <= PARITY;
          end
        end
        PARITY: begin
          if (fall) begin
            par_bit <= data_sync;
            state   <= STOP;
          end
        end
        STOP: begin
          if (fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Silence watchdog: only runs mid-frame and restarts on every fall.
      if (state == IDLE || fall) begin
        tocnt <= '0;
      end else if (timeout) begin
        tocnt <= '0;
        state <= IDLE;
      end else begin
        tocnt <= tocnt + 1'b1;
      end

      // Clear first so a same-cycle set wins.
      if (err_clr) begin
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (drop_ovf)              overflow  <= 1'b1;
      if (frame_bad || timeout)  frame_err <= 1'b1;
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (rd_en),
    .din   (shreg),
    .dout  (kbd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (kbd_count)
  );

  assign kbd_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx. A byte queue models the FIFO contents:
// bytes are pushed when a good frame is sent and compared as they are
// popped. Timeout is shortened so the whole run stays small.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int H     = 20;   // PS/2 half period in clk cycles

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en    = 1'b0;
  logic       err_clr  = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic [3:0] kbd_count;
  logic       overflow;
  logic       frame_err;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic       pv;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_count (kbd_count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check({tag, "_count"}, 32'(kbd_count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(kbd_valid), 32'(exp_q.size() != 0));
    check({tag, "_data"},  32'(kbd_data),  32'(head));
  endtask

  // Frame {stop, parity, data, start}; flip_par inverts the odd-parity bit.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic flip_par,
                                     input logic stop);
    logic p;
    p = ~(^d) ^ flip_par;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic idle_gap();
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_bits(mk(d, 1'b0, 1'b1), 11);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    idle_gap();
  endtask

  // Drive the stop bit; pre_valid is sampled one cycle before the push edge,
  // and err_clr/rd_en are applied on the edge that ends the fall cycle.
  task automatic stop_edge(input logic sv, input logic clr, input logic pop,
                           output logic pre_valid);
    @(negedge clk) ps2_data = sv;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 pre_valid = kbd_valid;
    @(negedge clk);
    err_clr = clr;
    rd_en   = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic stop_release();
    @(negedge clk);
    err_clr = 1'b0;
    rd_en   = 1'b0;
    repeat (H - 1) @(negedge clk);
    ps2_clk = 1'b1;
    idle_gap();
  endtask

  task automatic pop_one(input string tag);
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_fifo(tag);
  endtask

  task automatic clear_flags();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_fifo("rst");
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0x1C with exact push latency; rd_en in the push cycle while empty
    send_bits(mk(8'h1C, 1'b0, 1'b1), 10);
    stop_edge(1'b1, 1'b0, 1'b1, pv);
    check("t1_pre_valid", 32'(pv), 32'd0);
    exp_q.push_back(8'h1C);
    check_fifo("t1");
    check("t1_ferr", 32'(frame_err), 32'd0);
    stop_release();
    pop_one("t1_pop");

    // 2: two frames, then pops down to and past empty
    send_good(8'hF0);
    check_fifo("t2_f0");
    send_good(8'h1C);
    check_fifo("t2_1c");
    pop_one("t2_pop1");
    pop_one("t2_pop2");
    pop_one("t2_pop3");

    // 3: parity error, clear, and error coinciding with err_clr
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    idle_gap();
    check_fifo("t3_par");
    check("t3_par_ferr", 32'(frame_err), 32'd1);
    clear_flags();
    check("t3_clr_ferr", 32'(frame_err), 32'd0);
    send_bits(mk(8'h1C, 1'b1, 1'b1), 10);
    stop_edge(1'b1, 1'b1, 1'b0, pv);
    check("t3_set_wins", 32'(frame_err), 32'd1);
    stop_release();
    clear_flags();
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11);
    idle_gap();
    check_fifo("t3_stop");
    check("t3_stop_ferr", 32'(frame_err), 32'd1);
    clear_flags();

    // 4: overflow, then push+pop while full, then drain
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    check_fifo("t4_full");
    check("t4_ovf", 32'(overflow), 32'd1);
    clear_flags();
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    send_bits(mk(8'h0A, 1'b0, 1'b1), 10);
    stop_edge(1'b1, 1'b0, 1'b1, pv);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h0A);
    check_fifo("t4_pushpop");
    check("t4_pushpop_ovf", 32'(overflow), 32'd0);
    stop_release();
    for (int i = 0; i < DEPTH; i++) pop_one("t4_drain");

    // 5: stall mid-frame until the watchdog fires, then a clean frame
    send_bits(mk(8'h1C, 1'b0, 1'b1), 5);
    check("t5_before_to", 32'(frame_err), 32'd0);
    repeat (TO) @(negedge clk);
    check("t5_after_to", 32'(frame_err), 32'd1);
    clear_flags();
    idle_gap();
    send_good(8'h1C);
    check_fifo("t5_next");
    check("t5_next_ferr", 32'(frame_err), 32'd0);
    pop_one("t5_pop");

    // 6: reset mid-frame, then a frame after release, then an IDLE glitch
    send_good(8'h55);
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    idle_gap();
    check("t6_pre_ferr", 32'(frame_err), 32'd1);
    send_bits(mk(8'h66, 1'b0, 1'b1), 5);
    @(negedge clk) rst = 1'b0;
    #1;
    exp_q.delete();
    check_fifo("t6_rst");
    check("t6_rst_ferr", 32'(frame_err), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_good(8'h1C);
    check_fifo("t6_after");
    @(negedge clk) ps2_clk = 1'b0;
    @(negedge clk) ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    check_fifo("t6_glitch");
    check("t6_glitch_ferr", 32'(frame_err), 32'd0);
    send_good(8'h33);
    check_fifo("t6_post_glitch");
    check("t6_post_ferr", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
